div_iter_unit: RTL and testbench

DIV_ITER_UNIT -- requirements
Module: div_iter_unit

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 20 ++
 rtl/div_iter_unit.sv | 144 ++++++++++++++
 tb/tb_div_iter_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared state encoding and special-case result constants
// for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int MAX_LEN = 64;

  // Divide-by-zero quotient and signed-overflow remainder
  localparam logic [MAX_LEN-1:0] DZ_QUO  = '1;
  localparam logic [MAX_LEN-1:0] OVF_REM = '0;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract with
// carry-out and restore mux.
module div_step #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] part,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] res,
  output logic             qbit
);

  logic [WIDTH:0] sum;

  assign sum  = {1'b0, part}
              + {1'b0, ~dvs}
              + {{WIDTH{1'b0}}, 1'b1};
  assign qbit = sum[WIDTH];
  assign res  = qbit ? sum[WIDTH-1:0] : part;

endmodule

// File: rtl/div_iter_unit.sv
// Iterative signed/unsigned restoring divider, one
// quotient bit per cycle with valid/ready handshakes.
module div_iter_unit
  import div_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                div_valid,
  output logic                div_ready,
  input  logic                div_signed,
  input  logic [DATA_LEN-1:0] dividend,
  input  logic [DATA_LEN-1:0] divisor,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] quotient,
  output logic [DATA_LEN-1:0] remainder
);

  localparam int W  = DATA_LEN;
  localparam int CW = $clog2(DATA_LEN + 1);

  div_state_e state, state_nxt;

  logic [W-1:0]  q_reg;
  logic [W-1:0]  r_reg;
  logic [W-1:0]  dvs_reg;
  logic          neg_q;
  logic          neg_r;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          div_zero;
  logic          ovf;
  logic [W:0]    sext_a;
  logic [W:0]    sext_b;
  logic [W:0]    mag_a;
  logic [W:0]    mag_b;
  logic [W:0]    step_res;
  logic          step_q;
  logic          unused_bits;

  assign div_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign quotient  = q_reg;
  assign remainder = r_reg;

  assign accept   = div_valid & div_ready & ~flush;
  assign div_zero = (divisor == '0);
  assign ovf      = div_signed
                  & (dividend == {1'b1, {(W-1){1'b0}}})
                  & (divisor == '1);

  // One extra bit so the most-negative value negates cleanly
  assign sext_a = {div_signed & dividend[W-1], dividend};
  assign sext_b = {div_signed & divisor[W-1], divisor};
  assign mag_a  = sext_a[W] ? -sext_a : sext_a;
  assign mag_b  = sext_b[W] ? -sext_b : sext_b;

  div_step #(
    .WIDTH (W + 1)
  ) u_step (
    .part (({r_reg, q_reg[W-1]})),
    .dvs  ({1'b0, dvs_reg}),
    .res  (step_res),
    .qbit (step_q)
  );

  assign unused_bits = ^{mag_a[W], mag_b[W], step_res[W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_nxt = (div_zero | ovf) ? DONE : CALC;
      end
      CALC: begin
        if (cnt == CW'(1)) state_nxt = FIX;
      end
      FIX:  state_nxt = DONE;
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg   <= '0;
      r_reg   <= '0;
      dvs_reg <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      cnt     <= '0;
    end else if (!flush) begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              div_zero: begin
                q_reg <= DZ_QUO[W-1:0];
                r_reg <= dividend;
              end
              ovf: begin
                q_reg <= dividend;
                r_reg <= OVF_REM[W-1:0];
              end
              default: begin
                q_reg   <= mag_a[W-1:0];
                r_reg   <= '0;
                dvs_reg <= mag_b[W-1:0];
                neg_q   <= sext_a[W] ^ sext_b[W];
                neg_r   <= sext_a[W];
                cnt     <= CW'(W);
              end
            endcase
          end
        end
        CALC: begin
          q_reg <= {q_reg[W-2:0], step_q};
          r_reg <= step_res[W-1:0];
          cnt   <= cnt - CW'(1);
        end
        FIX: begin
          if (neg_q) q_reg <= -q_reg;
          if (neg_r) r_reg <= -r_reg;
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_unit.sv
// Directed-vector bench for div_iter_unit with
// hand-computed expected results and latencies.
module tb_div_iter_unit;

  logic        clk;
  logic        rst_n;
  logic        div_valid;
  logic        div_ready;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int total = 0;
  int bad   = 0;
  int lat;
  int seen;

  div_iter_unit #(
    .DATA_LEN (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Accept one request, then count edges until out_valid
  task automatic run(input logic s,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     output int l);
    div_signed = s;
    dividend   = a;
    divisor    = b;
    div_valid  = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    l = 0;
    for (int i = 1; i <= 100; i++) begin
      if (out_valid) begin
        l = i;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ready_after"}, 64'(div_ready), 64'd1);
  endtask

  task automatic op(input string tag,
                    input logic s,
                    input logic [31:0] a,
                    input logic [31:0] b,
                    input logic [31:0] eq,
                    input logic [31:0] er,
                    input int el);
    int l;
    run(s, a, b, l);
    chk({tag, "_lat"}, 64'(l), 64'(el));
    chk({tag, "_quo"}, 64'(quotient), 64'(eq));
    chk({tag, "_rem"}, 64'(remainder), 64'(er));
    take(tag);
  endtask

  initial begin
    rst_n      = 1'b0;
    div_valid  = 1'b0;
    div_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    #23;
    chk("rst_ready", 64'(div_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_quo", 64'(quotient), 64'd0);
    chk("rst_rem", 64'(remainder), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    op("u100_7", 1'b0, 32'd100, 32'd7,
       32'd14, 32'd2, 34);
    op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
       32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
    op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
       32'hFFFF_FFFD, 32'd1, 34);
    op("s_m100_m7", 1'b1, 32'hFFFF_FF9C,
       32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 34);
    op("u5_0", 1'b0, 32'd5, 32'd0,
       32'hFFFF_FFFF, 32'd5, 1);
    op("s5_0", 1'b1, 32'd5, 32'd0,
       32'hFFFF_FFFF, 32'd5, 1);
    op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
       32'h8000_0000, 32'd0, 1);
    op("u_ovfops", 1'b0, 32'h8000_0000,
       32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34);
    op("s_minneg_1", 1'b1, 32'h8000_0000, 32'd1,
       32'h8000_0000, 32'd0, 34);
    op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1,
       32'hFFFF_FFFF, 32'd0, 34);
    op("u_small_big", 1'b0, 32'd3, 32'd10,
       32'd0, 32'd3, 34);

    // Hold result while out_ready is low
    run(1'b0, 32'd1000, 32'd10, lat);
    chk("stall_lat", 64'(lat), 64'd34);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_ready", 64'(div_ready), 64'd0);
      chk("stall_quo", 64'(quotient), 64'd100);
      chk("stall_rem", 64'(remainder), 64'd0);
    end
    take("stall");
    chk("stall_valid_after", 64'(out_valid), 64'd0);

    // Flush mid-CALC
    div_signed = 1'b0;
    dividend   = 32'd12345;
    divisor    = 32'd3;
    div_valid  = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_ready", 64'(div_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("flush_no_valid", 64'(seen), 64'd0);

    // Reset pulse mid-CALC
    dividend  = 32'd999;
    divisor   = 32'd7;
    div_valid = 1'b1;
    @(posedge clk);
    #1;
    div_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #2;
    chk("rstpulse_ready", 64'(div_ready), 64'd1);
    chk("rstpulse_quo", 64'(quotient), 64'd0);
    #3;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("rstpulse_no_valid", 64'(seen), 64'd0);

    op("u_max_16", 1'b0, 32'hFFFF_FFFF, 32'd16,
       32'h0FFF_FFFF, 32'd15, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
